seg_scan_driver: RTL and testbench



---
 rtl/seg_pkg.sv | 28 ++
 rtl/char_to_seg.sv | 54 +++++
 rtl/seg_scan_driver.sv | 138 +++++++++++++
 tb/tb_seg_scan_driver.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared display types: character codes, segment constants, scan states.
// Imported by the display-content logic and by seg_scan_driver.
package seg_pkg;

    typedef logic [5:0] seg_char_t;

    // Codes 0-9 are the decimal digits themselves.
    localparam seg_char_t CH_BLANK = 6'd10;
    localparam seg_char_t CH_A = 6'd11, CH_B = 6'd12, CH_C = 6'd13;
    localparam seg_char_t CH_D = 6'd14, CH_E = 6'd15, CH_F = 6'd16;
    localparam seg_char_t CH_G = 6'd17, CH_H = 6'd18, CH_I = 6'd19;
    localparam seg_char_t CH_J = 6'd20, CH_K = 6'd21, CH_L = 6'd22;
    localparam seg_char_t CH_M = 6'd23, CH_N = 6'd24, CH_O = 6'd25;
    localparam seg_char_t CH_P = 6'd26, CH_Q = 6'd27, CH_R = 6'd28;
    localparam seg_char_t CH_S = 6'd29, CH_T = 6'd30, CH_U = 6'd31;
    localparam seg_char_t CH_V = 6'd32, CH_W = 6'd33, CH_X = 6'd34;
    localparam seg_char_t CH_Y = 6'd35, CH_Z = 6'd36;

    // Segment order {g,f,e,d,c,b,a}, active-low.
    localparam logic [6:0] BLANK_PATTERN = 7'b1111111;
    localparam logic [6:0] DASH_PATTERN  = 7'b0111111;

    typedef enum logic {
        GUARD = 1'b0,
        ON    = 1'b1
    } scan_state_t;

endpackage

// File: rtl/char_to_seg.sv
// Combinational decoder: 6-bit character code to active-low {g..a} pattern.
// Ports: code (character code in), seg (segment pattern out).
module char_to_seg
    import seg_pkg::*;
(
    input  seg_char_t  code,
    output logic [6:0] seg
);

    always_comb begin
        seg = DASH_PATTERN;
        case (code)
            6'd0:     seg = 7'b1000000;
            6'd1:     seg = 7'b1111001;
            6'd2:     seg = 7'b0100100;
            6'd3:     seg = 7'b0110000;
            6'd4:     seg = 7'b0011001;
            6'd5:     seg = 7'b0010010;
            6'd6:     seg = 7'b0000010;
            6'd7:     seg = 7'b1111000;
            6'd8:     seg = 7'b0000000;
            6'd9:     seg = 7'b0010000;
            CH_BLANK: seg = BLANK_PATTERN;
            CH_A:     seg = 7'b0001000;
            CH_B:     seg = 7'b0000011;
            CH_C:     seg = 7'b1000110;
            CH_D:     seg = 7'b0100001;
            CH_E:     seg = 7'b0000110;
            CH_F:     seg = 7'b0001110;
            CH_G:     seg = 7'b1000010;
            CH_H:     seg = 7'b0001001;
            CH_I:     seg = 7'b1111001;
            CH_J:     seg = 7'b1100001;
            CH_K:     seg = 7'b0001010;
            CH_L:     seg = 7'b1000111;
            CH_M:     seg = 7'b1101010;
            CH_N:     seg = 7'b0101011;
            CH_O:     seg = 7'b0100011;
            CH_P:     seg = 7'b0001100;
            CH_Q:     seg = 7'b0011000;
            CH_R:     seg = 7'b0101111;
            CH_S:     seg = 7'b0010010;
            CH_T:     seg = 7'b0000111;
            CH_U:     seg = 7'b1000001;
            CH_V:     seg = 7'b1100011;
            CH_W:     seg = 7'b1010101;
            CH_X:     seg = 7'b0001001;
            CH_Y:     seg = 7'b0010001;
            CH_Z:     seg = 7'b0100100;
            default:  seg = DASH_PATTERN;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// 8-digit multiplexed seven-segment scanner with guard blanking, blink, dp.
// Ports: clk_in, rst_n_in, seg_data_in[8], blink_in, dp_in -> an_out, cat_out, dp_out, frame_start_out.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int DIGIT_CYCLES = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int BLINK_FRAMES = 32
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  seg_char_t  seg_data_in [8],
    input  logic [7:0] blink_in,
    input  logic [7:0] dp_in,
    output logic [7:0] an_out,
    output logic [6:0] cat_out,
    output logic       dp_out,
    output logic       frame_start_out
);

    if (BLANK_CYCLES < 1 || DIGIT_CYCLES <= BLANK_CYCLES || BLINK_FRAMES < 1)
    begin : g_bad_params
        $error("seg_scan_driver: illegal cycle/frame parameters");
    end

    localparam int CW = $clog2(DIGIT_CYCLES);
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CW-1:0] CNT_LAST   = CW'(DIGIT_CYCLES - 1);
    localparam logic [CW-1:0] GUARD_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    scan_state_t     state, state_nx;
    logic [2:0]      idx, idx_nx;
    logic [CW-1:0]   cnt, cnt_nx;

    seg_char_t       shadow_code [8];
    logic [7:0]      shadow_blink;
    logic [7:0]      shadow_dp;
    logic            shadow_phase;

    logic [BW-1:0]   blink_cnt;
    logic            blink_phase;

    logic            frame_start;
    seg_char_t       cur_code;
    logic            cur_blink;
    logic            cur_dp;
    logic            cur_phase;
    logic            hide;
    logic [6:0]      dec_seg;

    assign frame_start     = (state == GUARD) && (idx == 3'd0) && (cnt == '0);
    assign frame_start_out = frame_start;

    // In the capture cycle the shadows are still stale, so take the
    // values being latched; the frame's blink phase is the one current
    // at its own frame start.
    assign cur_code  = frame_start ? seg_data_in[idx] : shadow_code[idx];
    assign cur_blink = frame_start ? blink_in[idx]    : shadow_blink[idx];
    assign cur_dp    = frame_start ? dp_in[idx]       : shadow_dp[idx];
    assign cur_phase = frame_start ? blink_phase      : shadow_phase;
    assign hide      = cur_blink & cur_phase;

    char_to_seg u_dec (
        .code (cur_code),
        .seg  (dec_seg)
    );

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        cnt_nx   = cnt + CW'(1);
        case (state)
            GUARD: begin
                if (cnt == GUARD_LAST) state_nx = ON;
            end
            ON: begin
                if (cnt == CNT_LAST) begin
                    cnt_nx   = '0;
                    idx_nx   = idx + 3'd1;
                    state_nx = GUARD;
                end
            end
            default: state_nx = GUARD;
        endcase
    end

    always_comb begin
        an_out = 8'hFF;
        if (state == ON) an_out[idx] = 1'b0;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state <= GUARD;
            idx   <= 3'd0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
            cnt   <= cnt_nx;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < 8; i++) shadow_code[i] <= CH_BLANK;
            shadow_blink <= 8'h00;
            shadow_dp    <= 8'h00;
            shadow_phase <= 1'b0;
            blink_cnt    <= '0;
            blink_phase  <= 1'b0;
        end else if (frame_start) begin
            for (int i = 0; i < 8; i++) shadow_code[i] <= seg_data_in[i];
            shadow_blink <= blink_in;
            shadow_dp    <= dp_in;
            shadow_phase <= blink_phase;
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end
        end
    end

    // Segments only move while the anodes are dark.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cat_out <= BLANK_PATTERN;
            dp_out  <= 1'b1;
        end else if (state == GUARD) begin
            cat_out <= hide ? BLANK_PATTERN : dec_seg;
            dp_out  <= hide | ~cur_dp;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with short slot/guard/blink parameters.
// Frame vectors from a table, plus mid-frame change, reset and blink sequences.
module tb_seg_scan_driver;
    import seg_pkg::*;

    localparam int DC    = 10;
    localparam int BC    = 2;
    localparam int BF    = 2;
    localparam int FRAME = 8 * DC;

    typedef struct packed {
        logic [7:0][5:0] code;
        logic [7:0]      dp;
        logic [7:0][6:0] cat;
        logic [7:0]      edp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    seg_char_t  seg_data [8];
    logic [7:0] blink_v;
    logic [7:0] dp_v;
    logic [7:0] an;
    logic [6:0] cat;
    logic       dpo;
    logic       fs;

    int         total = 0;
    int         bad = 0;
    logic [6:0] exp_cat [8];
    logic       exp_dp [8];
    logic       mid_en = 1'b0;
    vec_t       tbl [5];

    always #5 clk = ~clk;

    seg_scan_driver #(
        .DIGIT_CYCLES (DC),
        .BLANK_CYCLES (BC),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk_in          (clk),
        .rst_n_in        (rst_n),
        .seg_data_in     (seg_data),
        .blink_in        (blink_v),
        .dp_in           (dp_v),
        .an_out          (an),
        .cat_out         (cat),
        .dp_out          (dpo),
        .frame_start_out (fs)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, want);
        end
    endtask

    task automatic load(input vec_t v);
        for (int i = 0; i < 8; i++) begin
            seg_data[i] = v.code[i];
            exp_cat[i]  = v.cat[i];
            exp_dp[i]   = v.edp[i];
        end
        dp_v    = v.dp;
        blink_v = 8'h00;
    endtask

    task automatic set_all(input seg_char_t c, input logic [6:0] ec,
                           input logic ed);
        for (int i = 0; i < 8; i++) begin
            seg_data[i] = c;
            exp_cat[i]  = ec;
            exp_dp[i]   = ed;
        end
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, " an"}, an, 8'hFF);
        chk({nm, " cat"}, cat, 7'h7F);
        chk({nm, " dp"}, dpo, 1'b1);
    endtask

    // Called at the negedge of the frame_start cycle; returns at the
    // negedge following the last checked cycle.
    task automatic run_frame(input int len);
        for (int n = 0; n < len; n++) begin
            int slot;
            int c;
            logic [7:0] ean;
            slot = (n % FRAME) / DC;
            c    = n % DC;
            ean  = (c < BC) ? 8'hFF : ~(8'h01 << slot);
            chk($sformatf("an n=%0d", n), an, ean);
            chk($sformatf("frame_start n=%0d", n), fs, n == 0);
            if (c >= BC) begin
                chk($sformatf("cat d%0d n=%0d", slot, n), cat, exp_cat[slot]);
                chk($sformatf("dp d%0d n=%0d", slot, n), dpo, exp_dp[slot]);
            end
            if (mid_en && n == 35)
                for (int i = 0; i < 8; i++) seg_data[i] = 6'd8;
            @(negedge clk);
        end
    endtask

    initial begin
        tbl[0] = '{code: {8{6'd8}}, dp: 8'h00,
                   cat: {8{7'h00}}, edp: 8'hFF};
        tbl[1] = '{code: {6'd10, 6'd40, 6'd15, 6'd0,
                          6'd8, 6'd8, 6'd8, 6'd8},
                   dp: 8'h00,
                   cat: {7'h7F, 7'h3F, 7'h06, 7'h40,
                         7'h00, 7'h00, 7'h00, 7'h00},
                   edp: 8'hFF};
        tbl[2] = '{code: {6'd7, 6'd6, 6'd5, 6'd4,
                          6'd3, 6'd2, 6'd1, 6'd9},
                   dp: 8'hA5,
                   cat: {7'h78, 7'h02, 7'h12, 7'h19,
                         7'h30, 7'h24, 7'h79, 7'h10},
                   edp: 8'h5A};
        tbl[3] = '{code: {6'd63, 6'd37, 6'd31, 6'd26,
                          6'd22, 6'd18, 6'd13, 6'd11},
                   dp: 8'h00,
                   cat: {7'h3F, 7'h3F, 7'h41, 7'h0C,
                         7'h47, 7'h09, 7'h46, 7'h08},
                   edp: 8'hFF};
        tbl[4] = '{code: {{7{6'd10}}, 6'd0}, dp: 8'h80,
                   cat: {{7{7'h7F}}, 7'h40}, edp: 8'h7F};

        load(tbl[0]);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk_reset("reset");
        end
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 5; k++) begin
            load(tbl[k]);
            run_frame(FRAME);
        end

        // Inputs change while digit 3 is lit: rest of frame keeps old text.
        dp_v = 8'h00;
        set_all(6'd0, 7'h40, 1'b1);
        mid_en = 1'b1;
        run_frame(FRAME);
        mid_en = 1'b0;
        set_all(6'd8, 7'h00, 1'b1);
        run_frame(FRAME);

        // Asynchronous reset in the middle of digit 5's on time.
        dp_v = 8'hFF;
        set_all(6'd8, 7'h00, 1'b0);
        run_frame(56);
        chk("pre-reset an", an, 8'hDF);
        chk("pre-reset cat", cat, 7'h00);
        chk("pre-reset dp", dpo, 1'b0);
        #1 rst_n = 1'b0;
        #1 chk_reset("async reset");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk_reset("held reset");
        end

        // Fresh capture after release, then blink on digit 0.
        blink_v = 8'h01;
        dp_v    = 8'h01;
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        for (int f = 0; f < 5; f++) begin
            set_all(6'd8, 7'h00, 1'b1);
            exp_dp[0] = 1'b0;
            if (f == 2 || f == 3) begin
                exp_cat[0] = 7'h7F;
                exp_dp[0]  = 1'b1;
            end
            run_frame(FRAME);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
